// File: rtl/multdiv_writeback_arbiter_if.sv
// Bundle between the multdiv stage, the main pipeline writeback and the register-file write port.
// Handshake: the pipeline holds pipe_we/pipe_rd/pipe_data stable until it sees pipe_ack=1 in the
// same cycle; md_result_rdy is a single-cycle valid pulse with no back-pressure.
interface multdiv_writeback_arbiter_if;
  logic [31:0] md_result;
  logic        md_result_rdy;
  logic        md_mult_overflow;
  logic        md_div_error;
  logic [31:0] md_instruction;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        pipe_ack;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic        stall_req;
  logic [31:0] pending_mask;
  logic        overflow_err;

  modport master (
    output md_result, md_result_rdy, md_mult_overflow, md_div_error, md_instruction,
    output pipe_we, pipe_rd, pipe_data,
    input  pipe_ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  stall_req, pending_mask, overflow_err
  );

  modport slave (
    input  md_result, md_result_rdy, md_mult_overflow, md_div_error, md_instruction,
    input  pipe_we, pipe_rd, pipe_data,
    output pipe_ack, ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output stall_req, pending_mask, overflow_err
  );
endinterface

// File: rtl/multdiv_writeback_arbiter.sv
// Merges multdiv results onto the single register-file write port, queueing them behind the
// main pipeline and forcing a stall when a queued result starves or the queue fills.
module multdiv_writeback_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                         clock,
  input logic                         reset,
  multdiv_writeback_arbiter_if.slave  bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]       slot_rd   [DEPTH];
  logic [31:0]      slot_data [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    count;
  logic [3:0]       age;
  logic             overflow_q;

  logic [4:0]  inc_rd;
  logic [31:0] inc_data;
  logic        inc_valid, non_empty, full, stall;
  logic        fifo_grant, bypass, push, push_ok, drop, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Exceptions redirect to the status register; the divide code wins when both flags are set.
  always_comb begin
    inc_rd   = bus.md_instruction[26:22];
    inc_data = bus.md_result;
    if (bus.md_div_error) begin
      inc_rd   = 5'd30;
      inc_data = 32'd5;
    end else if (bus.md_mult_overflow) begin
      inc_rd   = 5'd30;
      inc_data = 32'd4;
    end
  end

  assign inc_valid  = bus.md_result_rdy && (inc_rd != 5'd0);
  assign non_empty  = (count != '0);
  assign full       = (count == CW'(DEPTH));
  assign stall      = full || (non_empty && (age >= 4'(STARVE_LIMIT)));
  assign fifo_grant = non_empty && (stall || !bus.pipe_we);
  assign bypass     = reset && !bus.pipe_we && !non_empty && inc_valid;
  assign push       = inc_valid && !bypass;
  assign pop        = fifo_grant;
  assign push_ok    = push && (!full || pop);
  assign drop       = push && full && !pop;

  assign bus.stall_req    = stall;
  assign bus.pipe_ack     = reset && bus.pipe_we && !stall;
  assign bus.overflow_err = overflow_q;

  // A pipeline write to r0 still consumes the port but drives no enable.
  always_comb begin
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'd0;
    if (fifo_grant) begin
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = slot_rd[rd_ptr];
      bus.data_writeReg    = slot_data[rd_ptr];
    end else if (bus.pipe_ack) begin
      if (bus.pipe_rd != 5'd0) begin
        bus.ctrl_writeEnable = 1'b1;
        bus.ctrl_writeReg    = bus.pipe_rd;
        bus.data_writeReg    = bus.pipe_data;
      end
    end else if (bypass) begin
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = inc_rd;
      bus.data_writeReg    = inc_data;
    end
  end

  always_comb begin
    bus.pending_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) bus.pending_mask[slot_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      age        <= '0;
      overflow_q <= 1'b0;
      slot_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_rd[i]   <= 5'd0;
        slot_data[i] <= 32'd0;
      end
    end else begin
      if (pop) begin
        slot_valid[rd_ptr] <= 1'b0;
        rd_ptr             <= ptr_inc(rd_ptr);
      end
      // When full, push and pop share a slot; the push assignment comes last and wins.
      if (push_ok) begin
        slot_rd[wr_ptr]    <= inc_rd;
        slot_data[wr_ptr]  <= inc_data;
        slot_valid[wr_ptr] <= 1'b1;
        wr_ptr             <= ptr_inc(wr_ptr);
      end
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (pop)                                            age <= '0;
      else if (non_empty && (age < 4'(STARVE_LIMIT)))     age <= age + 1'b1;
      if (drop) overflow_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_multdiv_writeback_arbiter.sv
// Directed vector bench for multdiv_writeback_arbiter (DEPTH=2, STARVE_LIMIT=4).
module tb_multdiv_writeback_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multdiv_writeback_arbiter_if bus ();

  multdiv_writeback_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rdy, mult, div;
    logic [4:0]  md_rd;
    logic [31:0] md_res;
    logic        pwe;
    logic [4:0]  prd;
    logic [31:0] pdata;
    logic        e_we;
    logic [4:0]  e_reg;
    logic [31:0] e_data;
    logic        e_ack, e_stall;
    logic [31:0] e_mask;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rdy, mult, div, input logic [4:0] md_rd,
                              input logic [31:0] md_res, input logic pwe,
                              input logic [4:0] prd, input logic [31:0] pdata,
                              input logic e_we, input logic [4:0] e_reg,
                              input logic [31:0] e_data, input logic e_ack, e_stall,
                              input logic [31:0] e_mask);
    vec_t v;
    v.rdy = rdy; v.mult = mult; v.div = div; v.md_rd = md_rd; v.md_res = md_res;
    v.pwe = pwe; v.prd = prd; v.pdata = pdata;
    v.e_we = e_we; v.e_reg = e_reg; v.e_data = e_data;
    v.e_ack = e_ack; v.e_stall = e_stall; v.e_mask = e_mask;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.md_result_rdy    = v.rdy;
    bus.md_mult_overflow = v.mult;
    bus.md_div_error     = v.div;
    bus.md_result        = v.md_res;
    bus.md_instruction   = {5'b10110, v.md_rd, 22'h2A5A5};
    bus.pipe_we          = v.pwe;
    bus.pipe_rd          = v.prd;
    bus.pipe_data        = v.pdata;
  endtask

  task automatic check_idle(input int row);
    check("we", row, 32'(bus.ctrl_writeEnable), 32'd0);
    check("ack", row, 32'(bus.pipe_ack), 32'd0);
    check("stall", row, 32'(bus.stall_req), 32'd0);
    check("mask", row, bus.pending_mask, 32'd0);
    check("reg", row, 32'(bus.ctrl_writeReg), 32'd0);
    check("data", row, bus.data_writeReg, 32'd0);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,5'd0,32'h0, 0,5'd0,32'h0, 0,5'd0,32'h0, 0,0,32'h0);
    drive(idle);
    // bypass and exception formation
    vq.push_back(idle);
    vq.push_back(mk(1,0,0,5'd7,32'h42,   0,5'd0,32'h0, 1,5'd7,32'h42, 0,0,32'h0));
    vq.push_back(idle);
    vq.push_back(mk(1,1,0,5'd12,32'hDEAD, 0,5'd0,32'h0, 1,5'd30,32'h4, 0,0,32'h0));
    vq.push_back(mk(1,0,1,5'd12,32'hBEEF, 0,5'd0,32'h0, 1,5'd30,32'h5, 0,0,32'h0));
    vq.push_back(mk(1,1,1,5'd12,32'h1234, 0,5'd0,32'h0, 1,5'd30,32'h5, 0,0,32'h0));
    vq.push_back(mk(1,0,0,5'd0,32'h77,    0,5'd0,32'h0, 0,5'd0,32'h0, 0,0,32'h0));
    vq.push_back(idle);
    // conflict and starvation
    vq.push_back(mk(1,0,0,5'd9,32'h99, 1,5'd3,32'h11, 1,5'd3,32'h11, 1,0,32'h0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,0,0,5'd0,32'h0, 1,5'd3,32'h11, 1,5'd3,32'h11, 1,0,32'h200));
    vq.push_back(mk(0,0,0,5'd0,32'h0, 1,5'd3,32'h11, 1,5'd9,32'h99, 0,1,32'h200));
    vq.push_back(mk(0,0,0,5'd0,32'h0, 1,5'd3,32'h11, 1,5'd3,32'h11, 1,0,32'h0));
    // fill, push-with-drain at full, continued pressure
    vq.push_back(mk(1,0,0,5'd5,32'h55,  1,5'd3,32'h11, 1,5'd3,32'h11, 1,0,32'h0));
    vq.push_back(mk(1,0,0,5'd6,32'h66,  1,5'd3,32'h11, 1,5'd3,32'h11, 1,0,32'h20));
    vq.push_back(mk(1,0,0,5'd8,32'h88,  1,5'd3,32'h11, 1,5'd5,32'h55, 0,1,32'h60));
    vq.push_back(mk(0,0,0,5'd0,32'h0,   1,5'd3,32'h11, 1,5'd6,32'h66, 0,1,32'h140));
    vq.push_back(mk(1,0,0,5'd10,32'hAA, 1,5'd3,32'h11, 1,5'd3,32'h11, 1,0,32'h100));
    vq.push_back(mk(1,0,0,5'd11,32'hBB, 1,5'd3,32'h11, 1,5'd8,32'h88, 0,1,32'h500));
    vq.push_back(mk(0,0,0,5'd0,32'h0,   1,5'd3,32'h11, 1,5'd10,32'hAA, 0,1,32'hC00));
    vq.push_back(mk(0,0,0,5'd0,32'h0,   0,5'd0,32'h0,  1,5'd11,32'hBB, 0,0,32'h800));
    vq.push_back(idle);
    // pipeline write to r0 uses the port, so the incoming result queues
    vq.push_back(mk(1,0,0,5'd13,32'hCC, 1,5'd0,32'h123, 0,5'd0,32'h0, 1,0,32'h0));
    vq.push_back(mk(0,0,0,5'd0,32'h0,   0,5'd0,32'h0,   1,5'd13,32'hCC, 0,0,32'h2000));
    vq.push_back(idle);

    #3;
    check_idle(-1);
    check("ovf", -1, 32'(bus.overflow_err), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vq[r]) begin
      @(negedge clock);
      drive(vq[r]);
      #3;
      check("we", r, 32'(bus.ctrl_writeEnable), 32'(vq[r].e_we));
      if (vq[r].e_we) begin
        check("reg", r, 32'(bus.ctrl_writeReg), 32'(vq[r].e_reg));
        check("data", r, bus.data_writeReg, vq[r].e_data);
      end
      check("ack", r, 32'(bus.pipe_ack), 32'(vq[r].e_ack));
      check("stall", r, 32'(bus.stall_req), 32'(vq[r].e_stall));
      check("mask", r, bus.pending_mask, vq[r].e_mask);
      check("ovf", r, 32'(bus.overflow_err), 32'd0);
    end

    // reset asserted between edges with two entries queued
    @(negedge clock);
    drive(mk(1,0,0,5'd14,32'hE1, 1,5'd3,32'h11, 0,5'd0,32'h0, 0,0,32'h0));
    @(negedge clock);
    drive(mk(1,0,0,5'd15,32'hE2, 1,5'd3,32'h11, 0,5'd0,32'h0, 0,0,32'h0));
    @(negedge clock);
    drive(mk(0,0,0,5'd0,32'h0, 1,5'd3,32'h11, 0,5'd0,32'h0, 0,0,32'h0));
    #1;
    check("pre_rst_stall", 100, 32'(bus.stall_req), 32'd1);
    check("pre_rst_mask", 100, bus.pending_mask, 32'hC000);
    #1;
    reset = 1'b0;
    #1;
    check_idle(101);
    @(negedge clock);
    drive(idle);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check_idle(102 + i);
      check("ovf", 102 + i, 32'(bus.overflow_err), 32'd0);
      @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
